// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-outstanding AXI4-lite memory slave sitting behind the
// cache master. One transaction at a time, fixed response latency, word-
// addressed storage with out-of-range detection (SLVERR).
module axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  aw_valid,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  output logic                  aw_ready,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  output logic                  b_valid,
  output logic [1:0]            b_resp,
  input  logic                  b_ready,
  input  logic                  ar_valid,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  output logic                  ar_ready,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  input  logic                  r_ready
);

  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  b_valid_q, r_valid_q;
  logic [1:0]            b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0] r_data_q;

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // In IDLE the read address comes straight off the bus (needed for the
  // zero-latency read); otherwise the latched address drives decode.
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [1:0]            rd_resp_d;
  logic                  unused_addr_bits;

  assign cur_addr         = (state_q == IDLE) ? ar_addr : addr_q;
  assign idx              = cur_addr[2 +: IDX_W];
  assign oor              = (cur_addr >> (IDX_W + 2)) != '0;
  assign unused_addr_bits = ^cur_addr[1:0];
  assign wr_en            = (state_q == WR_DATA) && w_valid && !oor;
  assign rd_data_d        = oor ? '0 : mem[idx];
  assign rd_resp_d        = oor ? RESP_ERR : RESP_OK;

  // Readies are pure decode of state (and aw_valid for write priority).
  assign aw_ready = (state_q == IDLE);
  assign ar_ready = (state_q == IDLE) && !aw_valid;
  assign w_ready  = (state_q == WR_DATA);

  assign b_valid = b_valid_q;
  assign b_resp  = b_resp_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_resp  = r_resp_q;

  // Write commits at the W handshake edge; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= w_data;
  end

  // Transaction FSM with registered response channels.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OK;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OK;
      r_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_valid) begin
            addr_q  <= aw_addr;
            state_q <= WR_DATA;
          end else if (ar_valid) begin
            addr_q <= ar_addr;
            if (LATENCY == 0) begin
              state_q   <= RD_RESP;
              r_valid_q <= 1'b1;
              r_data_q  <= rd_data_d;
              r_resp_q  <= rd_resp_d;
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WR_DATA: begin
          if (w_valid) begin
            b_resp_q <= oor ? RESP_ERR : RESP_OK;
            if (LATENCY == 0) begin
              state_q   <= WR_RESP;
              b_valid_q <= 1'b1;
            end else begin
              state_q <= WR_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WR_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= WR_RESP;
            b_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_RESP: begin
          if (b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= RD_RESP;
            r_valid_q <= 1'b1;
            r_data_q  <= rd_data_d;
            r_resp_q  <= rd_resp_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_RESP: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- MEM_DEPTH, 256, number of words (power of two)
- LATENCY, 2, wait cycles between accept and response (0..15)

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge
- n_rst, in, 1, asynchronous active-low reset
- aw_valid, in, 1, write address valid
- aw_addr, in, ADDR_WIDTH, write byte address
- aw_ready, out, 1, write address accepted
- w_valid, in, 1, write data valid
- w_data, in, DATA_WIDTH, write data
- w_ready, out, 1, write data accepted
- b_valid, out, 1, write response valid
- b_resp, out, 2, write response (00 OKAY, 10 SLVERR)
- b_ready, in, 1, master accepts write response
- ar_valid, in, 1, read address valid
- ar_addr, in, ADDR_WIDTH, read byte address
- ar_ready, out, 1, read address accepted
- r_valid, out, 1, read data valid
- r_data, out, DATA_WIDTH, read data
- r_resp, out, 2, read response (00 OKAY, 10 SLVERR)
- r_ready, in, 1, master accepts read data

Function
REQ-003 The block SHALL be the memory-side AXI4-lite slave driven by the cache AXI master, serving one transaction at a time.
REQ-004 The FSM SHALL have states IDLE, WR_DATA, WR_WAIT, WR_RESP, RD_WAIT and RD_RESP.
REQ-005 A handshake SHALL occur in any cycle where valid and ready are both high at the rising edge.
REQ-006 IDLE behaviour:
- aw_ready=1.
- ar_ready=~aw_valid, so a write wins when aw_valid and ar_valid are high in the same cycle.
- The read is not accepted that cycle and stays pending.
REQ-007 IDLE transitions:
- AW handshake: latch aw_addr and go to WR_DATA.
- AR handshake: latch ar_addr and go to RD_WAIT, or to RD_RESP if LATENCY=0.
REQ-008 WR_DATA behaviour:
- w_ready=1 and aw_ready=ar_ready=0.
- On W handshake, write w_data to the latched word at that edge.
- Then go to WR_WAIT, or to WR_RESP if LATENCY=0.
REQ-009 Word index SHALL be addr[2 +: log2(MEM_DEPTH)]; addr[1:0] SHALL be ignored, giving OKAY with the aligned access.
REQ-010 An address >= MEM_DEPTH*4 SHALL be out of range:
- A write is dropped (memory unchanged) with b_resp=10.
- A read returns r_data=0 with r_resp=10.
REQ-011 WAIT-state timing:
- A 4-bit down-counter is loaded with LATENCY-1 on entry to WR_WAIT or RD_WAIT.
- The state exits to its RESP state on the edge where the counter equals 0, otherwise it decrements.
REQ-012 Response timing:
- b_valid SHALL rise exactly LATENCY+1 cycles after the W-handshake cycle.
- r_valid SHALL rise exactly LATENCY+1 cycles after the AR-handshake cycle.
REQ-013 r_data and r_resp SHALL be registered on entry to RD_RESP and held stable while r_valid=1.
REQ-014 RD_RESP SHALL hold r_valid=1 until r_ready, then go to IDLE.
REQ-015 WR_RESP SHALL hold b_valid=1 and b_resp stable until b_ready, then go to IDLE.
REQ-016 Readies SHALL be 0 in all states except those listed in REQ-006 and REQ-008.
REQ-017 Back-to-back transactions SHALL be possible: the cycle after a B or R handshake, IDLE is active and accepts a new request.
REQ-018 aw_ready, ar_ready and w_ready SHALL be combinational from state and aw_valid only; b_valid and r_valid SHALL be registered.

Reset
REQ-019 On n_rst=0 the block SHALL asynchronously enter IDLE with:
- b_valid=r_valid=0
- b_resp=r_resp=00
- r_data=0
- counter=0
- latched address=0
REQ-020 Memory contents SHALL NOT be reset; a read of a never-written in-range word SHALL return undefined data with OKAY.
REQ-021 Reset asserted mid-transaction SHALL abort it with no response issued:
- A write already committed at its W handshake stays in memory.
- A write not yet committed is lost.
REQ-022 After reset deassertion, IDLE readies SHALL follow REQ-006 from the first clock edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios (stimulus -> required response), all with LATENCY=2:
- Write aw_addr=0x10, w_data=0xDEADBEEF with W handshake at cycle N -> b_valid=1, b_resp=00 at cycle N+3. Then read 0x10 with AR handshake at cycle M -> r_valid=1, r_data=0xDEADBEEF, r_resp=00 at cycle M+3.
- aw_valid and ar_valid high together in IDLE -> aw_ready=1, ar_ready=0. The write completes, then the read is accepted in the first IDLE cycle after the B handshake.
- Write aw_addr=0x400 (out of range, MEM_DEPTH=256) -> b_resp=10 with memory unchanged. Read 0x400 -> r_data=0, r_resp=10.
- r_ready held 0 for 5 cycles during RD_RESP -> r_valid and r_data stay stable for all 5 cycles, and the R handshake occurs on the cycle r_ready=1. Repeat with b_ready for B.
- n_rst pulsed low during WR_WAIT after a write of 0x12345678 to 0x20 -> b_valid=0 and IDLE immediately; a subsequent read of 0x20 returns 0x12345678.
- LATENCY=0 build: AR handshake at cycle N -> r_valid=1 at cycle N+1.
